// File: rtl/latch_bank_wr_seq.sv
// Write/clear/preset sequencer for a bank of transparent-high latches.
// Every latch-facing output is a flop, timed in CLK cycles by a three-process FSM.
module latch_bank_wr_seq #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AW        = 2,
  parameter int SETUP_CYC = 2,
  parameter int PW_CYC    = 3,
  parameter int HOLD_CYC  = 1,
  parameter int REC_CYC   = 2
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  input  logic             set_req,
  output logic [WIDTH-1:0] lat_d,
  output logic [DEPTH-1:0] lat_en,
  output logic             lat_rstb,
  output logic             lat_setb,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CLR   = 3'd4,
    SET   = 3'd5,
    RECOV = 3'd6
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PW_LAST    = 8'(PW_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] REC_LAST   = 8'(REC_CYC - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             clr_pend_q, clr_pend_d;
  logic             set_pend_q, set_pend_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic [DEPTH-1:0] lat_en_q, lat_en_d;
  logic             lat_rstb_q, lat_rstb_d;
  logic             lat_setb_q, lat_setb_d;
  logic             wr_ready_q, wr_ready_d;
  logic             busy_q, busy_d;
  logic             accept;

  // wr_ready_q is only ever high in IDLE with nothing pending
  assign accept = wr_ready_q & wr_valid;

  // State register and cycle counter.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= RECOV;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: each timed state leaves once cnt reaches its count minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (clr_pend_q) begin
          state_d = CLR;
        end else if (set_pend_q) begin
          state_d = SET;
        end else if (accept) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = PULSE;
          cnt_d   = 8'd0;
        end else begin
          state_d = SETUP;
        end
      end
      PULSE: begin
        if (cnt_q == PW_LAST) begin
          state_d = HOLD;
          cnt_d   = 8'd0;
        end else begin
          state_d = PULSE;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          state_d = HOLD;
        end
      end
      CLR, SET: begin
        if (cnt_q == PW_LAST) begin
          state_d = RECOV;
          cnt_d   = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      RECOV: begin
        if (cnt_q == REC_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          state_d = RECOV;
        end
      end
      default: begin
        state_d = RECOV;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs for the next cycle, derived from the next state so they can be registered.
  always_comb begin
    // A pulse landing on the entry cycle finds its flag still set and is merged
    if (state_d == CLR && state_q != CLR) begin
      clr_pend_d = 1'b0;
    end else begin
      clr_pend_d = clr_pend_q | clr_req;
    end
    if (state_d == SET && state_q != SET) begin
      set_pend_d = 1'b0;
    end else begin
      set_pend_d = set_pend_q | set_req;
    end

    if (accept) begin
      addr_d  = wr_addr;
      lat_d_d = wr_data;
    end else begin
      addr_d  = addr_q;
      lat_d_d = lat_d_q;
    end

    // Out-of-range addresses match no bit, so the pulse is silently dropped
    lat_en_d = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      lat_en_d[i] = (state_d == PULSE) && (addr_q == AW'(i));
    end

    lat_rstb_d = (state_d != CLR);
    lat_setb_d = (state_d != SET);
    wr_ready_d = (state_d == IDLE) && !clr_pend_d && !set_pend_d;
    busy_d     = (state_d != IDLE) || clr_pend_d || set_pend_d;
  end

  // Datapath, request flags and latch-facing output flops.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      clr_pend_q <= 1'b0;
      set_pend_q <= 1'b0;
      addr_q     <= {AW{1'b0}};
      lat_d_q    <= {WIDTH{1'b0}};
      lat_en_q   <= {DEPTH{1'b0}};
      lat_rstb_q <= 1'b0;
      lat_setb_q <= 1'b1;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      clr_pend_q <= clr_pend_d;
      set_pend_q <= set_pend_d;
      addr_q     <= addr_d;
      lat_d_q    <= lat_d_d;
      lat_en_q   <= lat_en_d;
      lat_rstb_q <= lat_rstb_d;
      lat_setb_q <= lat_setb_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign lat_d    = lat_d_q;
  assign lat_en   = lat_en_q;
  assign lat_rstb = lat_rstb_q;
  assign lat_setb = lat_setb_q;
  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;

endmodule
